// File: rtl/lwb_pkg.sv
// line_word_bridge shared types.
// Op codes, FSM states and the word-offset helper.
package lwb_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB_GO,
    S_WB_DATA,
    S_WB_WAIT,
    S_RD_GO,
    S_RD_DATA,
    S_RD_WAIT,
    S_RESP
  } state_e;

  function automatic int lwb_off(input int line_w, input int word_w);
    return $clog2(line_w / word_w);
  endfunction

endpackage

// File: rtl/line_buf.sv
// One cache-line buffer for line_word_bridge.
// Word read/merge by index and full-line load.
module line_buf #(
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int WPL        = 16,
  parameter int IDX_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic                  i_wr,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [WORD_WIDTH-1:0] i_wdata,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic [LINE_WIDTH-1:0] o_line
);

  logic [WPL-1:0][WORD_WIDTH-1:0] r_line;

  // Full-line fill has priority over a single-word merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_wr) begin
      r_line[i_idx] <= i_wdata;
    end
  end

  assign o_word = r_line[i_idx];
  assign o_line = r_line;

endmodule

// File: rtl/line_word_bridge.sv
// CPU word port to DMA cache-line bridge.
// One buffered line with tag/valid/dirty, fill-on-miss, write-back, flush.
module line_word_bridge #(
  parameter int WORD_WIDTH     = 32,
  parameter int LINE_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int SIZE_WIDTH     = 43
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      host_init,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [1:0]                op,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_WIDTH-1:0]     cpu_wdata,
  output logic [WORD_WIDTH-1:0]     cpu_rdata,
  output logic                      ready,
  output logic                      tx_done,
  output logic                      rd_valid,
  output logic [ADDR_WIDTH-1:0]     dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]     dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]     dma_rd_size,
  output logic [SIZE_WIDTH-1:0]     dma_wr_size,
  output logic                      dma_rd_go,
  output logic                      dma_wr_go,
  input  logic                      dma_empty,
  input  logic                      dma_full,
  output logic                      dma_rd_en,
  output logic                      dma_wr_en,
  input  logic [LINE_WIDTH-1:0]     dma_rd_data,
  output logic [LINE_WIDTH-1:0]     dma_wr_data,
  input  logic                      dma_rd_done,
  input  logic                      dma_wr_done
);

  import lwb_pkg::*;

  localparam int WPL   = LINE_WIDTH / WORD_WIDTH;
  localparam int OFF   = lwb_off(LINE_WIDTH, WORD_WIDTH);
  localparam int LB_SH = $clog2(LINE_WIDTH / 8);
  localparam int TAG_W = CPU_ADDR_WIDTH - OFF;

  state_e                    r_state;
  op_e                       r_op;
  logic                      r_armed;
  logic                      r_valid;
  logic                      r_dirty;
  logic [TAG_W-1:0]          r_tag;
  logic [CPU_ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0]     r_wdata;
  logic [WORD_WIDTH-1:0]     r_rdata;
  logic [ADDR_WIDTH-1:0]     r_rd_addr;
  logic [ADDR_WIDTH-1:0]     r_wr_addr;
  logic                      r_tx_done;
  logic                      r_rd_valid;

  op_e                       w_op;
  logic [TAG_W-1:0]          w_tag;
  logic [TAG_W-1:0]          w_ltag;
  logic [OFF-1:0]            w_lidx;
  logic                      w_hit;
  logic                      w_buf_load;
  logic                      w_buf_wr;
  logic [WORD_WIDTH-1:0]     w_word;
  logic [LINE_WIDTH-1:0]     w_line;

  // Byte address of a line; wraps modulo 2^ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] f_line_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [TAG_W-1:0]      tag
  );
    return base + (ADDR_WIDTH'(tag) << LB_SH);
  endfunction

  assign w_op       = op_e'(op);
  assign w_tag      = cpu_addr[CPU_ADDR_WIDTH-1:OFF];
  assign w_ltag     = r_addr[CPU_ADDR_WIDTH-1:OFF];
  assign w_lidx     = r_addr[OFF-1:0];
  assign w_hit      = r_valid && (w_tag == r_tag);
  assign w_buf_load = (r_state == S_RD_DATA) && !dma_empty;
  assign w_buf_wr   = (r_state == S_RESP) && (r_op == OP_WRITE);

  assign ready       = r_armed && (r_state == S_IDLE);
  assign tx_done     = r_tx_done;
  assign rd_valid    = r_rd_valid;
  assign cpu_rdata   = r_rdata;
  assign dma_rd_addr = r_rd_addr;
  assign dma_wr_addr = r_wr_addr;
  assign dma_rd_size = SIZE_WIDTH'(1);
  assign dma_wr_size = SIZE_WIDTH'(1);
  assign dma_rd_go   = (r_state == S_RD_GO);
  assign dma_wr_go   = (r_state == S_WB_GO);
  assign dma_rd_en   = w_buf_load;
  assign dma_wr_en   = (r_state == S_WB_DATA) && !dma_full;
  assign dma_wr_data = w_line;

  line_buf #(
    .WORD_WIDTH (WORD_WIDTH),
    .LINE_WIDTH (LINE_WIDTH),
    .WPL        (WPL),
    .IDX_W      (OFF)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_buf_load),
    .i_line  (dma_rd_data),
    .i_wr    (w_buf_wr),
    .i_idx   (w_lidx),
    .i_wdata (r_wdata),
    .o_word  (w_word),
    .o_line  (w_line)
  );

  // Control FSM: accept, write-back, fill, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_armed    <= 1'b0;
      r_valid    <= 1'b0;
      r_dirty    <= 1'b0;
      r_tag      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_tx_done  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_tx_done  <= 1'b0;
      r_rd_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (host_init) begin
            r_armed <= 1'b1;
            r_valid <= 1'b0;
            r_dirty <= 1'b0;
          end else if (r_armed && w_op != OP_NOP) begin
            r_op    <= w_op;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            if (w_op == OP_FLUSH) begin
              if (r_valid && r_dirty) begin
                r_wr_addr <= f_line_addr(base_addr, r_tag);
                r_state   <= S_WB_GO;
              end else begin
                r_state <= S_RESP;
              end
            end else if (w_hit) begin
              r_state <= S_RESP;
            end else begin
              r_rd_addr <= f_line_addr(base_addr, w_tag);
              if (r_dirty) begin
                r_wr_addr <= f_line_addr(base_addr, r_tag);
                r_state   <= S_WB_GO;
              end else begin
                r_state <= S_RD_GO;
              end
            end
          end
        end
        S_WB_GO:   r_state <= S_WB_DATA;
        S_WB_DATA: if (!dma_full) r_state <= S_WB_WAIT;
        S_WB_WAIT: begin
          if (dma_wr_done) begin
            r_state <= (r_op == OP_FLUSH) ? S_RESP : S_RD_GO;
          end
        end
        S_RD_GO:   r_state <= S_RD_DATA;
        S_RD_DATA: begin
          if (!dma_empty) begin
            r_tag   <= w_ltag;
            r_valid <= 1'b1;
            r_dirty <= 1'b0;
            r_state <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: if (dma_rd_done) r_state <= S_RESP;
        S_RESP: begin
          r_tx_done <= 1'b1;
          if (r_op == OP_READ) begin
            r_rdata    <= w_word;
            r_rd_valid <= 1'b1;
          end
          if (r_op == OP_WRITE) r_dirty <= 1'b1;
          if (r_op == OP_FLUSH) r_dirty <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_word_bridge.sv
// Self-checking bench for line_word_bridge.
// Vector table plus directed flush/wrap/reset/stale-done sequences.
module tb_line_word_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         host_init;
  logic [63:0]  base_addr;
  logic [1:0]   op;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         ready;
  logic         tx_done;
  logic         rd_valid;
  logic [63:0]  dma_rd_addr;
  logic [63:0]  dma_wr_addr;
  logic [42:0]  dma_rd_size;
  logic [42:0]  dma_wr_size;
  logic         dma_rd_go;
  logic         dma_wr_go;
  logic         dma_empty;
  logic         dma_full;
  logic         dma_rd_en;
  logic         dma_wr_en;
  logic [511:0] dma_rd_data;
  logic [511:0] dma_wr_data;
  logic         dma_rd_done;
  logic         dma_wr_done;

  int n_chk  = 0;
  int n_fail = 0;

  int           n_rd_go    = 0;
  int           n_wr_go    = 0;
  int           n_rd_en    = 0;
  int           n_wr_en    = 0;
  int           n_bad_rd   = 0;
  int           n_bad_wr   = 0;
  int           rd_delay   = 0;
  int           rd_cnt     = 0;
  logic         rd_pend    = 1'b0;
  logic         m_rd_done  = 1'b0;
  logic         m_wr_done  = 1'b0;
  logic [511:0] m_rd_data  = '0;
  logic [511:0] wr_data_seen = '0;
  logic [63:0]  rd_addr_seen = '0;
  logic [63:0]  wr_addr_seen = '0;

  line_word_bridge dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_init   (host_init),
    .base_addr   (base_addr),
    .op          (op),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .ready       (ready),
    .tx_done     (tx_done),
    .rd_valid    (rd_valid),
    .dma_rd_addr (dma_rd_addr),
    .dma_wr_addr (dma_wr_addr),
    .dma_rd_size (dma_rd_size),
    .dma_wr_size (dma_wr_size),
    .dma_rd_go   (dma_rd_go),
    .dma_wr_go   (dma_wr_go),
    .dma_empty   (dma_empty),
    .dma_full    (dma_full),
    .dma_rd_en   (dma_rd_en),
    .dma_wr_en   (dma_wr_en),
    .dma_rd_data (dma_rd_data),
    .dma_wr_data (dma_wr_data),
    .dma_rd_done (dma_rd_done),
    .dma_wr_done (dma_wr_done)
  );

  always #5 clk = ~clk;

  // Host line contents: word i of the line at byte address a is a[31:0]+i.
  function automatic logic [511:0] mk_line(input logic [63:0] a);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = a[31:0] + 32'(i);
    return l;
  endfunction

  assign dma_empty   = !(rd_pend && rd_cnt == 0);
  assign dma_rd_done = m_rd_done;
  assign dma_wr_done = m_wr_done;
  assign dma_rd_data = m_rd_data;

  // DMA engine model: done cleared on go, set after the data beat.
  always @(posedge clk) begin
    if (dma_rd_go) begin
      n_rd_go      <= n_rd_go + 1;
      rd_addr_seen <= dma_rd_addr;
      m_rd_done    <= 1'b0;
      rd_pend      <= 1'b1;
      rd_cnt       <= rd_delay;
      m_rd_data    <= mk_line(dma_rd_addr);
    end else if (dma_rd_en) begin
      n_rd_en   <= n_rd_en + 1;
      rd_pend   <= 1'b0;
      m_rd_done <= 1'b1;
    end else if (rd_pend && rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
    if (dma_rd_en && dma_empty) n_bad_rd <= n_bad_rd + 1;
    if (dma_wr_go) begin
      n_wr_go      <= n_wr_go + 1;
      wr_addr_seen <= dma_wr_addr;
      m_wr_done    <= 1'b0;
    end
    if (dma_wr_en) begin
      n_wr_en      <= n_wr_en + 1;
      wr_data_seen <= dma_wr_data;
      m_wr_done    <= 1'b1;
      if (dma_full) n_bad_wr <= n_bad_wr + 1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_init(input logic [63:0] b);
    base_addr = b;
    host_init = 1'b1;
    @(posedge clk); #1;
    host_init = 1'b0;
  endtask

  // Issue one op; lat is the cycle index of tx_done (accept edge ends cycle 0).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] d, output int lat,
                       output logic rv, output logic [31:0] rd);
    int k;
    lat = 0;
    rv  = 1'b0;
    rd  = '0;
    k   = 0;
    while (!ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!ready) begin
      chk("ready_wait", 64'(ready), 64'(1));
      return;
    end
    op = o; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    op = 2'b00; cpu_addr = '1; cpu_wdata = '0;
    lat = 1;
    while (!tx_done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rv = rd_valid;
    rd = cpu_rdata;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
    int          rdgo;
    int          wrgo;
  } vec_t;

  vec_t vt[8];

  initial begin
    int          lat;
    logic        rv;
    logic [31:0] rd;
    int          rg, wg, re, we;
    logic        ok;

    vt[0] = '{2'b01,  5, 0,            32'h1005,     5, 1, 0};
    vt[1] = '{2'b01,  6, 0,            32'h1006,     2, 0, 0};
    vt[2] = '{2'b10,  3, 32'hDEADBEEF, 0,            2, 0, 0};
    vt[3] = '{2'b01,  3, 0,            32'hDEADBEEF, 2, 0, 0};
    vt[4] = '{2'b01, 20, 0,            32'h1044,     8, 1, 1};
    vt[5] = '{2'b10, 17, 32'h12345678, 0,            2, 0, 0};
    vt[6] = '{2'b01, 17, 0,            32'h12345678, 2, 0, 0};
    vt[7] = '{2'b01, 16, 0,            32'h1040,     2, 0, 0};

    rst_n = 1'b0; host_init = 1'b0; base_addr = '0;
    op = 2'b00; cpu_addr = '0; cpu_wdata = '0;
    dma_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_pulses", 64'({tx_done, rd_valid, dma_rd_go, dma_wr_go,
                           dma_rd_en, dma_wr_en}), 64'(0));
    chk("rst_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_addrs", dma_rd_addr | dma_wr_addr, 64'(0));
    chk("rst_wdata", 64'(|dma_wr_data), 64'(0));
    chk("rst_sizes", 64'({dma_rd_size[7:0], dma_wr_size[7:0]}), 64'h0101);

    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; cpu_addr = 5;
    repeat (3) @(posedge clk);
    #1;
    op = 2'b00;
    chk("disarmed_ready", 64'(ready), 64'(0));
    chk("disarmed_no_go", 64'(n_rd_go), 64'(0));

    do_init(64'h1000);
    chk("armed_ready", 64'(ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      rg = n_rd_go; wg = n_wr_go;
      do_op(vt[i].op, vt[i].addr, vt[i].wdata, lat, rv, rd);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_rv", i), 64'(rv), 64'(vt[i].op == 2'b01));
      if (vt[i].op == 2'b01)
        chk($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].exp));
      chk($sformatf("v%0d_rdgo", i), 64'(n_rd_go - rg), 64'(vt[i].rdgo));
      chk($sformatf("v%0d_wrgo", i), 64'(n_wr_go - wg), 64'(vt[i].wrgo));
    end
    chk("wb_addr", wr_addr_seen, 64'h1000);
    chk("wb_word3", 64'(wr_data_seen[3*32 +: 32]), 64'hDEADBEEF);
    chk("wb_word5", 64'(wr_data_seen[5*32 +: 32]), 64'h1005);
    chk("fill_addr", rd_addr_seen, 64'h1040);

    // Flush of a dirty line with the write FIFO full for 10 cycles.
    wg = n_wr_go; we = n_wr_en;
    dma_full = 1'b1;
    fork
      begin
        repeat (10) @(posedge clk);
        #1 dma_full = 1'b0;
      end
    join_none
    do_op(2'b11, 0, 0, lat, rv, rd);
    chk("flush_lat", 64'(lat), 64'(13));
    chk("flush_wrgo", 64'(n_wr_go - wg), 64'(1));
    chk("flush_wren", 64'(n_wr_en - we), 64'(1));
    chk("flush_en_full", 64'(n_bad_wr), 64'(0));
    chk("flush_addr", wr_addr_seen, 64'h1040);
    chk("flush_word1", 64'(wr_data_seen[1*32 +: 32]), 64'h12345678);

    wg = n_wr_go; rg = n_rd_go;
    do_op(2'b11, 0, 0, lat, rv, rd);
    chk("flush2_lat", 64'(lat), 64'(2));
    chk("flush2_dma", 64'((n_wr_go - wg) + (n_rd_go - rg)), 64'(0));
    do_op(2'b01, 17, 0, lat, rv, rd);
    chk("post_flush_lat", 64'(lat), 64'(2));
    chk("post_flush_rd", 64'(rd), 64'h12345678);

    // Line address wraps past 2^64.
    do_init(64'hFFFF_FFFF_FFFF_FFC0);
    rg = n_rd_go;
    do_op(2'b01, 16, 0, lat, rv, rd);
    chk("wrap_lat", 64'(lat), 64'(5));
    chk("wrap_rdgo", 64'(n_rd_go - rg), 64'(1));
    chk("wrap_addr", rd_addr_seen, 64'h0);
    chk("wrap_rdata", 64'(rd), 64'h0);

    // Reset while waiting for fill data.
    do_init(64'h1000);
    rd_delay = 50;
    op = 2'b01; cpu_addr = 5;
    @(posedge clk); #1;
    op = 2'b00;
    chk("mid_rd_go", 64'(dma_rd_go), 64'(1));
    @(posedge clk); #1;
    chk("mid_rd_en_empty", 64'(dma_rd_en), 64'(0));
    rg = n_rd_go; re = n_rd_en;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(ready), 64'(0));
    chk("arst_pulses", 64'({tx_done, rd_valid, dma_rd_go, dma_wr_go,
                            dma_rd_en, dma_wr_en}), 64'(0));
    chk("arst_addrs", dma_rd_addr | dma_wr_addr, 64'(0));
    chk("arst_data", 64'(cpu_rdata) | 64'(|dma_wr_data), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (ready || tx_done || dma_rd_go || dma_rd_en ||
          dma_wr_go || dma_wr_en) ok = 1'b0;
    end
    chk("post_rst_quiet", 64'(ok), 64'(1));
    chk("post_rst_rdgo", 64'(n_rd_go - rg), 64'(0));
    chk("post_rst_rden", 64'(n_rd_en - re), 64'(0));

    // Stale done level from the previous fill must not end the next one.
    do_init(64'h1000);
    rd_delay = 0;
    do_op(2'b01, 5, 0, lat, rv, rd);
    chk("rearm_lat", 64'(lat), 64'(5));
    chk("rearm_rdata", 64'(rd), 64'h1005);
    rd_delay = 3;
    re = n_rd_en;
    do_op(2'b01, 20, 0, lat, rv, rd);
    chk("stale_lat", 64'(lat), 64'(8));
    chk("stale_rdata", 64'(rd), 64'h1044);
    chk("stale_rden", 64'(n_rd_en - re), 64'(1));
    chk("rd_en_empty", 64'(n_bad_rd), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_word_bridge.md
# line_word_bridge

Parametrised successor to the AFU memory controller. It sits between the soft CPU's word-level load/store port and the DMA cache-line interface. It holds one line-sized buffer (tag, valid, dirty) so that repeated word accesses to the same line need no DMA traffic. It adds write-back, fill-on-miss, explicit flush and configurable word/line/address widths.

## Interface
Parameters:
- WORD_WIDTH, 32, CPU data word width; must divide LINE_WIDTH
- LINE_WIDTH, 512, DMA cache-line width
- ADDR_WIDTH, 64, virtual byte address width
- CPU_ADDR_WIDTH, 32, CPU word-address width
- SIZE_WIDTH, 43, DMA size field width

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- host_init  in  1  one-cycle go from the memory map; arms the bridge and invalidates the buffer
- base_addr  in  ADDR_WIDTH  byte address of CPU word 0 in host memory
- op  in  2  00 NOP, 01 READ, 10 WRITE, 11 FLUSH
- cpu_addr  in  CPU_ADDR_WIDTH  word address
- cpu_wdata  in  WORD_WIDTH  write data
- cpu_rdata  out  WORD_WIDTH  read data; valid only when rd_valid=1
- ready  out  1  bridge can accept an op this cycle
- tx_done  out  1  one-cycle pulse on completion of any op
- rd_valid  out  1  one-cycle pulse with READ completion
- dma_rd_addr / dma_wr_addr  out  ADDR_WIDTH  line byte address
- dma_rd_size / dma_wr_size  out  SIZE_WIDTH  held at constant 1
- dma_rd_go / dma_wr_go  out  1  one-cycle start pulses
- dma_empty, dma_full  in  1  DMA FIFO status
- dma_rd_en / dma_wr_en  out  1  pop and push strobes
- dma_rd_data  in  LINE_WIDTH; dma_wr_data  out  LINE_WIDTH
- dma_rd_done / dma_wr_done  in  1  DMA completion levels

## Operation
- Derived constants: WPL = LINE_WIDTH/WORD_WIDTH; OFF = log2(WPL); LINE_BYTES = LINE_WIDTH/8.
- Address split: tag = cpu_addr >> OFF; word select = cpu_addr[OFF-1:0].
- Line byte address = base_addr + (tag << log2(LINE_BYTES)), computed modulo 2^ADDR_WIDTH, so it wraps silently.
- Arming:
  - Out of reset the bridge is disarmed: ready=0.
  - host_init arms it and clears valid and dirty.
  - host_init is ignored while state is not IDLE.
- Hit (valid and tag match):
  - READ returns the selected word.
  - WRITE merges cpu_wdata into the selected word slot and sets dirty.
- Miss:
  - If dirty, write back the buffered line to its old tag's address first.
  - Then fill from the new tag, set valid, clear dirty, and perform the op.
- FLUSH: write back if valid and dirty, then clear dirty. The line stays valid.
- State machine:
  - IDLE: accepts an op.
    - Hit → RESP.
    - Miss and dirty → WB_GO.
    - Miss and clean → RD_GO.
    - FLUSH and dirty → WB_GO.
    - FLUSH and clean → RESP.
  - WB_GO: pulse dma_wr_go → WB_DATA.
  - WB_DATA: when dma_full=0, assert dma_wr_en for 1 cycle with the buffer on dma_wr_data → WB_WAIT.
  - WB_WAIT: on dma_wr_done → RD_GO if the op is a miss, else RESP.
  - RD_GO: pulse dma_rd_go → RD_DATA.
  - RD_DATA: when dma_empty=0, pulse dma_rd_en and capture dma_rd_data → RD_WAIT.
  - RD_WAIT: on dma_rd_done → RESP.
  - RESP: apply the op, pulse tx_done (and rd_valid for READ) → IDLE.
- Latched op: op, cpu_addr and cpu_wdata are captured at accept. Inputs are don't-care afterwards.

## Timing
- Reset values: every output is 0, state=IDLE, valid=dirty=0, disarmed.
  - Exception: dma_rd_size and dma_wr_size read 1 at all times.
- Reset mid-transfer: the bridge aborts immediately and issues no further DMA strobes.
- ready=1 only in IDLE while armed. An op is accepted when ready=1 and op≠NOP.
- Hit latency: tx_done (and rd_valid) is 2 cycles after the accept edge: IDLE→RESP→pulse.
- dma_*_done is ignored in the cycle that carries the go pulse. The DMA clears its done flag on go, so a stale done from a prior transfer is never sampled.
- dma_rd_addr and dma_wr_addr are registered. They are stable from the go cycle until the done level is seen.
- Clean miss minimum: accept, RD_GO, RD_DATA, RD_WAIT, RESP.
- Dirty miss adds the WB_GO, WB_DATA and WB_WAIT cycles ahead of the fill.
- cpu_rdata holds its value until the next READ completes.

## Structure
- Package lwb_pkg:
  - op enum (NOP/READ/WRITE/FLUSH)
  - state enum (IDLE, WB_GO, WB_DATA, WB_WAIT, RD_GO, RD_DATA, RD_WAIT, RESP)
  - function clog2-based OFF
- Sub-module line_buf: stores the LINE_WIDTH register, provides word select/merge by index, and performs the full-line load.
- Top level: FSM, tag/valid/dirty registers and address arithmetic.

## Test plan
- Reset then host_init, base_addr=0x1000; READ addr 5 → one dma_rd_go with dma_rd_addr=0x1000; returned line word 5 appears on cpu_rdata with rd_valid and tx_done.
- READ addr 6 directly after → no DMA activity; rd_valid exactly 2 cycles after accept.
- WRITE addr 3 = 0xDEADBEEF, then READ addr 20 → write-back to 0x1000 with word 3 = 0xDEADBEEF, then fill from 0x1040.
- FLUSH on a dirty line with dma_full held high 10 cycles → dma_wr_en only after full drops; exactly one write-back; a second FLUSH completes with no DMA activity.
- base_addr=0xFFFF_FFFF_FFFF_FFC0, READ addr 16 → dma_rd_addr=0x0 (wrap).
- Assert rst_n low during RD_DATA → all outputs 0 and ready=0 until the next host_init; a stale dma_rd_done=1 at RD_GO is not taken as completion.
